// File: rtl/bin_to_bcd_display.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_display
//
// Iterative double-dabble converter feeding the 8-digit seven-segment
// controller. An unsigned binary value is accepted through a valid/ready
// handshake. It is converted one shift per clock, and the packed 8-digit BCD
// word is presented on a registered output together with a one-cycle done
// pulse. Digit i occupies bits [4i+3:4i], so digit 0 is the rightmost display.
// Inputs above MAX_VALUE saturate to 9999_9999 and raise overflow_out.
//
// Parameters:
//   INPUT_WIDTH  width of bin_in (4..32)
//   MAX_VALUE    largest value representable on 8 digits
//
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-high reset
//   bin_in        unsigned value, sampled on accept
//   valid_in      conversion request
//   ready_out     idle and accepting this cycle (low while rst_in is high)
//   bcd_out       8 packed BCD digits, holds the last result
//   valid_out     one-cycle pulse when bcd_out has just updated
//   overflow_out  last accepted input exceeded MAX_VALUE
//   blank_out     (BCD_BLANK_EN only) leading-zero blanking mask, bit 0 always 0
//
// Optional feature macro: BCD_BLANK_EN
// -----------------------------------------------------------------------------
module bin_to_bcd_display #(
   parameter int INPUT_WIDTH = 27,
   parameter int MAX_VALUE   = 99_999_999
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [INPUT_WIDTH-1:0] bin_in,
   input  logic                   valid_in,
   output logic                   ready_out,
   output logic [31:0]            bcd_out,
   output logic                   valid_out,
`ifdef BCD_BLANK_EN
   output logic [7:0]             blank_out,
`endif
   output logic                   overflow_out
);

   localparam int SR_W  = 32 + INPUT_WIDTH;
   localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [SR_W-1:0]   r_sr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic [31:0]       r_bcd;
   logic              r_valid;
   logic              r_overflow;
   logic [31:0]       w_bcd_adj;
   logic [SR_W-1:0]   w_sr_shift;
   logic [63:0]       w_bin_ext;
   logic              w_ovf;
   logic [31:0]       w_result;

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [31:0] add3_digits(input logic [31:0] d);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < 8; i++) begin
         if (d[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [31:0] saturate(input logic [31:0] d, input logic ovf);
      return ovf ? 32'h9999_9999 : d;
   endfunction

`ifdef BCD_BLANK_EN
   // Bit i set when digit i and every digit above it are zero; digit 0 always shown.
   function automatic logic [7:0] blank_mask(input logic [31:0] d, input logic ovf);
      logic [7:0] m;
      logic       all_zero;
      m        = 8'h00;
      all_zero = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         all_zero = all_zero && (d[4*i +: 4] == 4'd0);
         m[i]     = all_zero;
      end
      return ovf ? 8'h00 : m;
   endfunction

   logic [7:0] r_blank;
   assign blank_out = r_blank;
`endif

   // Widen before comparing so the check is exact for any legal INPUT_WIDTH;
   // for narrow inputs it folds to constant 0.
   assign w_bin_ext  = 64'(bin_in);
   assign w_ovf      = (w_bin_ext > 64'(MAX_VALUE));
   assign w_bcd_adj  = add3_digits(r_sr[SR_W-1 -: 32]);
   assign w_sr_shift = {w_bcd_adj[30:0], r_sr[INPUT_WIDTH-1:0], 1'b0};
   assign w_result   = saturate(r_sr[SR_W-1 -: 32], r_ovf);

   assign ready_out    = (r_state == S_IDLE) && !rst_in;
   assign bcd_out      = r_bcd;
   assign valid_out    = r_valid;
   assign overflow_out = r_overflow;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (valid_in) w_next_state = S_SHIFT;
         // Counter holds the number of shifts already done; this cycle does the last.
         S_SHIFT: if (r_cnt == CNT_W'(INPUT_WIDTH - 1)) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_sr       <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_bcd      <= 32'h0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
`ifdef BCD_BLANK_EN
         r_blank    <= 8'b1111_1110;
`endif
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (valid_in) begin
                  r_sr  <= {32'h0, bin_in};
                  r_cnt <= '0;
                  r_ovf <= w_ovf;
               end
            end
            S_SHIFT: begin
               r_sr  <= w_sr_shift;
               r_cnt <= r_cnt + 1'b1;
            end
            S_DONE: begin
               r_bcd      <= w_result;
               r_overflow <= r_ovf;
               r_valid    <= 1'b1;
`ifdef BCD_BLANK_EN
               r_blank    <= blank_mask(r_sr[SR_W-1 -: 32], r_ovf);
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
module tb_bin_to_bcd_display;

   logic        clk_in;
   logic        rst_in;
   logic [26:0] bin_in;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] bcd_out;
   logic        valid_out;
   logic        overflow_out;
`ifdef BCD_BLANK_EN
   logic [7:0]  blank_out;
`endif

   int n_pass;
   int n_total;

   bin_to_bcd_display #(.INPUT_WIDTH(27), .MAX_VALUE(99_999_999)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .bin_in       (bin_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .bcd_out      (bcd_out),
      .valid_out    (valid_out),
`ifdef BCD_BLANK_EN
      .blank_out    (blank_out),
`endif
      .overflow_out (overflow_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Wait (bounded) for ready, present v for one accept edge. Returns 1 ns after the accept edge.
   task automatic start(input logic [26:0] v);
      int n;
      n = 0;
      while (!ready_out && n < 100) begin
         @(posedge clk_in); #1;
         n++;
      end
      bin_in   = v;
      valid_in = 1'b1;
      @(posedge clk_in); #1;
      valid_in = 1'b0;
   endtask

   // Count edges until valid_out is seen; returns 999 if it never comes.
   task automatic wait_done(output int cycles);
      cycles = 999;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk_in); #1;
         if (valid_out) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_in = 1'b1; valid_in = 1'b0; bin_in = '0;
      #12;
      n_total++;
      if (bcd_out !== 32'h0 || valid_out !== 1'b0 || overflow_out !== 1'b0)
         $display("FAIL reset_outputs: bcd=%h valid=%b ovf=%b, want 0/0/0", bcd_out, valid_out, overflow_out);
      else n_pass++;
      n_total++;
      if (ready_out !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_out);
      else n_pass++;
`ifdef BCD_BLANK_EN
      n_total++;
      if (blank_out !== 8'b1111_1110) $display("FAIL reset_blank: got %b want 11111110", blank_out);
      else n_pass++;
`endif
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      #1;
      n_total++;
      if (ready_out !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ready_out);
      else n_pass++;
   endtask

   task automatic test_zero;
      int c;
      start(27'd0);
      wait_done(c);
      n_total++;
      if (c !== 28) $display("FAIL zero_latency: got %0d want 28", c);
      else n_pass++;
      n_total++;
      if (bcd_out !== 32'h0 || overflow_out !== 1'b0)
         $display("FAIL zero_value: bcd=%h ovf=%b want 00000000/0", bcd_out, overflow_out);
      else n_pass++;
      @(posedge clk_in); #1;
      n_total++;
      if (valid_out !== 1'b0) $display("FAIL zero_pulse_width: valid=%b want 0", valid_out);
      else n_pass++;
   endtask

   task automatic test_values;
      int c;
      start(27'd12_345_678);
      wait_done(c);
      n_total++;
      if (c !== 28 || bcd_out !== 32'h1234_5678 || overflow_out !== 1'b0)
         $display("FAIL val_12345678: lat=%0d bcd=%h ovf=%b want 28/12345678/0", c, bcd_out, overflow_out);
      else n_pass++;
      start(27'd99_999_999);
      wait_done(c);
      n_total++;
      if (c !== 28 || bcd_out !== 32'h9999_9999 || overflow_out !== 1'b0)
         $display("FAIL val_max: lat=%0d bcd=%h ovf=%b want 28/99999999/0", c, bcd_out, overflow_out);
      else n_pass++;
      start(27'd90_817_263);
      wait_done(c);
      n_total++;
      if (bcd_out !== 32'h9081_7263) $display("FAIL val_90817263: got %h want 90817263", bcd_out);
      else n_pass++;
   endtask

   task automatic test_overflow;
      int c;
      start(27'd100_000_000);
      wait_done(c);
      n_total++;
      if (bcd_out !== 32'h9999_9999 || overflow_out !== 1'b1)
         $display("FAIL ovf_sat: bcd=%h ovf=%b want 99999999/1", bcd_out, overflow_out);
      else n_pass++;
`ifdef BCD_BLANK_EN
      n_total++;
      if (blank_out !== 8'h00) $display("FAIL ovf_blank: got %b want 00000000", blank_out);
      else n_pass++;
`endif
      start(27'd7);
      wait_done(c);
      n_total++;
      if (bcd_out !== 32'h0000_0007 || overflow_out !== 1'b0)
         $display("FAIL ovf_clear: bcd=%h ovf=%b want 00000007/0", bcd_out, overflow_out);
      else n_pass++;
   endtask

   task automatic test_busy_ignore;
      int pulses;
      int first;
      int ready_bad;
      start(27'd42);
      pulses = 0; first = 0; ready_bad = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin bin_in = 27'd555; valid_in = 1'b1; end
         if (k == 7) valid_in = 1'b0;
         @(posedge clk_in); #1;
         if (k <= 27 && ready_out !== 1'b0) ready_bad++;
         if (valid_out) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      n_total++;
      if (pulses !== 1 || first !== 28)
         $display("FAIL busy_pulses: count=%0d at=%0d want 1 at 28", pulses, first);
      else n_pass++;
      n_total++;
      if (ready_bad !== 0) $display("FAIL busy_ready: ready high in %0d busy cycles, want 0", ready_bad);
      else n_pass++;
      n_total++;
      if (bcd_out !== 32'h0000_0042) $display("FAIL busy_value: got %h want 00000042", bcd_out);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int c;
      int stray;
      start(27'd1234);
      repeat (10) @(posedge clk_in);
      #3;
      rst_in = 1'b1;
      #1;
      n_total++;
      if (bcd_out !== 32'h0 || valid_out !== 1'b0 || overflow_out !== 1'b0 || ready_out !== 1'b0)
         $display("FAIL midrst_async: bcd=%h valid=%b ovf=%b rdy=%b want 0/0/0/0",
                  bcd_out, valid_out, overflow_out, ready_out);
      else n_pass++;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      #1;
      n_total++;
      if (ready_out !== 1'b1) $display("FAIL midrst_ready: got %b want 1", ready_out);
      else n_pass++;
      stray = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk_in); #1;
         if (valid_out) stray++;
      end
      n_total++;
      if (stray !== 0) $display("FAIL midrst_no_valid: got %0d pulses want 0", stray);
      else n_pass++;
      start(27'd9);
      wait_done(c);
      n_total++;
      if (c !== 28 || bcd_out !== 32'h0000_0009)
         $display("FAIL midrst_after: lat=%0d bcd=%h want 28/00000009", c, bcd_out);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int c;
      bin_in   = 27'd5;
      valid_in = 1'b1;
      @(posedge clk_in); #1;
      bin_in = 27'd6;
      wait_done(c);
      n_total++;
      if (c !== 28 || bcd_out !== 32'h0000_0005)
         $display("FAIL b2b_first: lat=%0d bcd=%h want 28/00000005", c, bcd_out);
      else n_pass++;
      wait_done(c);
      valid_in = 1'b0;
      n_total++;
      if (c !== 29 || bcd_out !== 32'h0000_0006)
         $display("FAIL b2b_second: gap=%0d bcd=%h want 29/00000006", c, bcd_out);
      else n_pass++;
      // A third accept may have happened on the IDLE cycle; let it drain.
      wait_done(c);
      @(posedge clk_in); #1;
   endtask

`ifdef BCD_BLANK_EN
   task automatic test_blank;
      int c;
      start(27'd405);
      wait_done(c);
      n_total++;
      if (blank_out !== 8'b1111_1000) $display("FAIL blank_405: got %b want 11111000", blank_out);
      else n_pass++;
      start(27'd0);
      wait_done(c);
      n_total++;
      if (blank_out !== 8'b1111_1110) $display("FAIL blank_0: got %b want 11111110", blank_out);
      else n_pass++;
      start(27'd10_000_000);
      wait_done(c);
      n_total++;
      if (blank_out !== 8'b0000_0000) $display("FAIL blank_10M: got %b want 00000000", blank_out);
      else n_pass++;
   endtask
`endif

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_zero();
      test_values();
      test_overflow();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
`ifdef BCD_BLANK_EN
      test_blank();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Iterative double-dabble converter sitting directly upstream of the 8-digit seven-segment controller.
- Takes an unsigned binary value (MIDI/note counters, debug values) and produces the packed 8-digit BCD word for the controller's 32-bit value input.
- Digit i occupies bits [4i+3:4i], so digit 0 is the rightmost display.
- Multi-cycle, one shift per clock, with a valid/ready input handshake and a one-cycle done pulse.

Parameters:
- INPUT_WIDTH, 27, width of the binary input. Legal range 4..32.
- MAX_VALUE, 99_999_999, largest value representable on 8 digits. Inputs above this saturate.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- bin_in  input  INPUT_WIDTH  unsigned value to convert; sampled on accept
- valid_in  input  1  request to convert bin_in
- ready_out  output  1  block is idle and will accept on this cycle
- bcd_out  output  32  8 packed BCD digits, registered; holds the last result
- valid_out  output  1  one-cycle pulse when bcd_out has just updated
- overflow_out  output  1  registered; 1 if the last accepted input exceeded MAX_VALUE

Behaviour:
- Reset (asynchronous, rst_in=1):
  - State goes to IDLE.
  - bcd_out=32'h0, valid_out=0, overflow_out=0.
  - Internal shift register and counter are cleared.
  - ready_out=0 while rst_in is high.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - ready_out=1.
  - On valid_in=1, capture bin_in into the binary shift field, clear the BCD field and counter, and go to SHIFT.
  - Overflow check at capture: if bin_in > MAX_VALUE, set the internal overflow flag. For INPUT_WIDTH <= 26 this is constant 0.
- SHIFT:
  - ready_out=0; valid_in is ignored and not queued.
  - Each cycle, in one step: every BCD nibble >= 5 gets +3, then the combined {bcd, bin} register (32+INPUT_WIDTH bits) shifts left by 1.
  - The counter increments. After exactly INPUT_WIDTH shifts, go to DONE.
- DONE (one cycle):
  - bcd_out <= result, or 32'h9999_9999 if the overflow flag is set.
  - overflow_out <= flag; valid_out=1 for this cycle only.
  - Next state is IDLE.
- Latency: accept on edge T gives valid_out high in cycle T+INPUT_WIDTH+1, which is 28 cycles at the default.
- Throughput: a new accept is possible on the cycle after DONE, so one conversion per INPUT_WIDTH+2 cycles.
- bcd_out and overflow_out change only in DONE or on reset. The downstream display never sees intermediate values.
- Simultaneous events:
  - valid_in held high continuously: a new conversion starts on every IDLE cycle, each time with the current bin_in.
  - rst_in asserted mid-SHIFT: the conversion is abandoned, outputs go to reset values, and no valid_out is produced.
- Every bcd_out nibble is always in 0..9; no A-F codes are ever emitted.

Optional Feature:
- Macro: BCD_BLANK_EN.
- Defined:
  - Adds output port blank_out [7:0], registered and updated in DONE alongside bcd_out.
  - Bit i=1 when digit i and every digit above it are zero (leading-zero blanking). Bit 0 is always 0 so "0" still displays.
  - Reset value is 8'b1111_1110.
  - On overflow, blank_out=8'h00.
- Undefined: port absent, no blanking logic; all other behaviour identical.

Test Plan:
- Reset, then bin_in=0, valid_in pulse -> valid_out exactly 28 cycles after accept, bcd_out=32'h0000_0000, overflow_out=0.
- bin_in=12_345_678 -> bcd_out=32'h1234_5678. Then bin_in=99_999_999 -> bcd_out=32'h9999_9999, overflow_out=0.
- bin_in=100_000_000 -> bcd_out=32'h9999_9999, overflow_out=1. Next conversion of 7 -> 32'h0000_0007, overflow_out=0.
- Accept 42, pulse valid_in with 555 during SHIFT -> single valid_out, bcd_out=32'h0000_0042, ready_out=0 throughout SHIFT.
- Accept 1234, assert rst_in asynchronously 10 cycles in -> outputs 0 immediately, no valid_out. After release, ready_out=1 and conversion of 9 -> 32'h0000_0009.
- With BCD_BLANK_EN: 405 -> blank_out=8'b1111_1000; 0 -> 8'b1111_1110; 10_000_000 -> 8'b0000_0000.
